// File: rtl/univ_shift_pkg.sv
// Shared mode encoding and helpers for the universal shift register.
package univ_shift_pkg;

   typedef enum logic [2:0] {
      MODE_HOLD = 3'd0,
      MODE_SHL  = 3'd1,
      MODE_SHR  = 3'd2,
      MODE_ROL  = 3'd3,
      MODE_ROR  = 3'd4,
      MODE_ASR  = 3'd5,
      MODE_LOAD = 3'd6,
      MODE_CLR  = 3'd7
   } shift_mode_t;

   // Modes 1..5 move bits and advance the word counter.
   function automatic logic is_shift(input logic [2:0] mode);
      return (mode >= 3'd1) && (mode <= 3'd5);
   endfunction

endpackage

// File: rtl/univ_shift_cnt.sv
// Modulo-WIDTH shift counter with a registered one-cycle word_done pulse on wrap.
module univ_shift_cnt #(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          inc,
   input  logic          clr,
   output logic [CW-1:0] cnt,
   output logic          word_done
);

   logic [CW-1:0] cnt_reg;
   logic [CW-1:0] cnt_next;
   logic          done_reg;
   logic          done_next;

   always_comb begin
      cnt_next  = cnt_reg;
      done_next = 1'b0;
      if (clr) begin
         cnt_next = '0;
      end else if (inc) begin
         if (cnt_reg == CW'(WIDTH - 1)) begin
            cnt_next  = '0;
            done_next = 1'b1;
         end else begin
            cnt_next = cnt_reg + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt_reg  <= '0;
         done_reg <= 1'b0;
      end else begin
         cnt_reg  <= cnt_next;
         done_reg <= done_next;
      end
   end

   assign cnt       = cnt_reg;
   assign word_done = done_reg;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: shift/rotate/ASR/load/clear with serial out and word counter.
// Define UNIV_SHIFT_PARITY_EN to add the parity and parity_word outputs.
module univ_shift_reg
   import univ_shift_pkg::*;
#(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         en,
   input  logic [2:0]                   mode,
   input  logic                         sin,
   input  logic [WIDTH-1:0]             pin,
   output logic [WIDTH-1:0]             out,
   output logic                         sout,
   output logic [$clog2(WIDTH+1)-1:0]   cnt,
   output logic                         word_done
`ifdef UNIV_SHIFT_PARITY_EN
   ,
   output logic                         parity,
   output logic                         parity_word
`endif
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] out_reg;
   logic [WIDTH-1:0] out_next;
   logic             sout_reg;
   logic             sout_next;
   logic             inc;
   logic             clr;

   always_comb begin
      out_next  = out_reg;
      sout_next = sout_reg;
      if (en) begin
         case (shift_mode_t'(mode))
            MODE_SHL: begin
               out_next  = {out_reg[WIDTH-2:0], sin};
               sout_next = out_reg[WIDTH-1];
            end
            MODE_SHR: begin
               out_next  = {sin, out_reg[WIDTH-1:1]};
               sout_next = out_reg[0];
            end
            MODE_ROL: begin
               out_next  = {out_reg[WIDTH-2:0], out_reg[WIDTH-1]};
               sout_next = out_reg[WIDTH-1];
            end
            MODE_ROR: begin
               out_next  = {out_reg[0], out_reg[WIDTH-1:1]};
               sout_next = out_reg[0];
            end
            MODE_ASR: begin
               out_next  = {out_reg[WIDTH-1], out_reg[WIDTH-1:1]};
               sout_next = out_reg[0];
            end
            MODE_LOAD: out_next = pin;
            MODE_CLR:  out_next = '0;
            default:   ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         out_reg  <= RST_VAL;
         sout_reg <= 1'b0;
      end else begin
         out_reg  <= out_next;
         sout_reg <= sout_next;
      end
   end

   assign inc = en && is_shift(mode);
   assign clr = en && ((mode == MODE_LOAD) || (mode == MODE_CLR));

   univ_shift_cnt #(
      .WIDTH (WIDTH),
      .CW    (CW)
   ) u_cnt (
      .clk       (clk),
      .rstn      (rstn),
      .inc       (inc),
      .clr       (clr),
      .cnt       (cnt),
      .word_done (word_done)
   );

   assign out  = out_reg;
   assign sout = sout_reg;

`ifdef UNIV_SHIFT_PARITY_EN
   logic parity_word_reg;
   logic wrap;

   // Capture on the same edge that raises word_done, so parity_word matches the completed word.
   assign wrap = inc && (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (!rstn) begin
         parity_word_reg <= 1'b0;
      end else if (wrap) begin
         parity_word_reg <= ^out_next;
      end
   end

   assign parity      = ^out_reg;
   assign parity_word = parity_word_reg;
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg: directed table, hand sequences, randomized vs model.
module tb_univ_shift_reg;

   localparam int             W  = 8;
   localparam logic [W-1:0]   RV = 8'hA5;
   localparam int             CW = $clog2(W + 1);

   logic          clk = 1'b0;
   logic          rstn;
   logic          en;
   logic [2:0]    mode;
   logic          sin;
   logic [W-1:0]  pin;
   logic [W-1:0]  out;
   logic          sout;
   logic [CW-1:0] cnt;
   logic          word_done;
`ifdef UNIV_SHIFT_PARITY_EN
   logic          parity;
   logic          parity_word;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   int   m_out;
   bit   m_sout;
   int   m_cnt;
   bit   m_done;
   bit   m_pw;

   typedef struct {
      bit       en;
      bit [2:0] mode;
      bit       sin;
      bit [7:0] pin;
      bit [7:0] e_out;
      bit       e_sout;
      int       e_cnt;
      bit       e_done;
   } vec_t;

   vec_t vecs[$];

   univ_shift_reg #(.WIDTH(W), .RST_VAL(RV)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .en        (en),
      .mode      (mode),
      .sin       (sin),
      .pin       (pin),
      .out       (out),
      .sout      (sout),
      .cnt       (cnt),
      .word_done (word_done)
`ifdef UNIV_SHIFT_PARITY_EN
      ,
      .parity      (parity),
      .parity_word (parity_word)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic bit par(input int v);
      bit p = 1'b0;
      for (int i = 0; i < W; i++) p ^= v[i];
      return p;
   endfunction

   // Model computed with plain integer arithmetic on the word value.
   task automatic model_step(input bit r, input bit e, input int md, input bit s, input int p);
      int mask = (1 << W) - 1;
      int msb  = 1 << (W - 1);
      if (!r) begin
         m_out = int'(RV); m_sout = 0; m_cnt = 0; m_done = 0; m_pw = 0;
         return;
      end
      m_done = 0;
      if (!e) return;
      case (md)
         1: begin m_sout = (m_out & msb) != 0; m_out = ((m_out << 1) | s) & mask; end
         2: begin m_sout = m_out & 1; m_out = (m_out >> 1) | (s ? msb : 0); end
         3: begin m_sout = (m_out & msb) != 0; m_out = ((m_out << 1) & mask) | (m_out >> (W - 1)); end
         4: begin m_sout = m_out & 1; m_out = (m_out >> 1) | ((m_out & 1) ? msb : 0); end
         5: begin m_sout = m_out & 1; m_out = (m_out >> 1) | (m_out & msb); end
         6: begin m_out = p & mask; m_cnt = 0; end
         7: begin m_out = 0; m_cnt = 0; end
         default: ;
      endcase
      if (md >= 1 && md <= 5) begin
         m_cnt  = (m_cnt + 1) % W;
         m_done = (m_cnt == 0);
         if (m_done) m_pw = par(m_out);
      end
   endtask

   task automatic cyc(input bit r, input bit e, input int md, input bit s, input int p);
      rstn = r; en = e; mode = 3'(md); sin = s; pin = W'(p);
      @(posedge clk);
      model_step(r, e, md, s, p);
      #1;
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".out"},  32'(out),       32'(m_out));
      chk({tag, ".sout"}, 32'(sout),      32'(m_sout));
      chk({tag, ".cnt"},  32'(cnt),       32'(m_cnt));
      chk({tag, ".done"}, 32'(word_done), 32'(m_done));
`ifdef UNIV_SHIFT_PARITY_EN
      chk({tag, ".parity"},  32'(parity),      32'(par(m_out)));
      chk({tag, ".pword"},   32'(parity_word), 32'(m_pw));
`endif
   endtask

   task automatic add_vec(input bit e, input int md, input bit s, input int p,
                          input int eo, input bit es, input int ec, input bit ed);
      vec_t v;
      v.en = e; v.mode = 3'(md); v.sin = s; v.pin = 8'(p);
      v.e_out = 8'(eo); v.e_sout = es; v.e_cnt = ec; v.e_done = ed;
      vecs.push_back(v);
   endtask

   initial begin
      bit   cap[8] = '{1, 0, 1, 1, 0, 0, 1, 0};
      int   pulses;
      rstn = 1'b0; en = 1'b0; mode = 3'd0; sin = 1'b0; pin = '0;

      // Rotate/ASR then serial capture; rows start right after reset (sout=0).
      add_vec(1, 6, 0, 8'h81, 8'h81, 0, 0, 0);
      add_vec(1, 3, 0, 0,     8'h03, 1, 1, 0);
      add_vec(1, 4, 0, 0,     8'h81, 1, 2, 0);
      add_vec(1, 5, 0, 0,     8'hC0, 1, 3, 0);
      add_vec(1, 2, 0, 0,     8'h60, 0, 4, 0);
      add_vec(1, 6, 0, 8'h00, 8'h00, 0, 0, 0);
      add_vec(1, 1, 1, 0,     8'h01, 0, 1, 0);
      add_vec(1, 1, 0, 0,     8'h02, 0, 2, 0);
      add_vec(1, 1, 1, 0,     8'h05, 0, 3, 0);
      add_vec(1, 1, 1, 0,     8'h0B, 0, 4, 0);
      add_vec(1, 1, 0, 0,     8'h16, 0, 5, 0);
      add_vec(1, 1, 0, 0,     8'h2C, 0, 6, 0);
      add_vec(1, 1, 1, 0,     8'h59, 0, 7, 0);
      add_vec(1, 1, 0, 0,     8'hB2, 0, 0, 1);
      add_vec(1, 0, 0, 0,     8'hB2, 0, 0, 0);

      // Reset with LOAD requested: reset wins.
      cyc(0, 1, 6, 0, 8'hFF);
      cyc(0, 1, 6, 0, 8'hFF);
      chk("rst.out",  32'(out), 32'h A5);
      chk("rst.cnt",  32'(cnt), 0);
      chk("rst.done", 32'(word_done), 0);
      chk("rst.sout", 32'(sout), 0);
`ifdef UNIV_SHIFT_PARITY_EN
      chk("rst.pword", 32'(parity_word), 0);
`endif

      foreach (vecs[i]) begin
         cyc(1, vecs[i].en, vecs[i].mode, vecs[i].sin, vecs[i].pin);
         $display("vec %0d mode=%0d sin=%0d -> out=%02h sout=%0d cnt=%0d done=%0d",
                  i, vecs[i].mode, vecs[i].sin, out, sout, cnt, word_done);
         chk($sformatf("vec%0d.out", i),  32'(out),       32'(vecs[i].e_out));
         chk($sformatf("vec%0d.sout", i), 32'(sout),      32'(vecs[i].e_sout));
         chk($sformatf("vec%0d.cnt", i),  32'(cnt),       32'(vecs[i].e_cnt));
         chk($sformatf("vec%0d.done", i), 32'(word_done), 32'(vecs[i].e_done));
      end
`ifdef UNIV_SHIFT_PARITY_EN
      chk("par.word_b2", 32'(parity_word), 0);
      cyc(1, 1, 6, 0, 8'h07);
      chk("par.load07", 32'(parity), 1);
`endif

      // Capture with an en=0 gap after the 4th shift.
      cyc(1, 1, 6, 0, 8'h00);
      for (int i = 0; i < 8; i++) begin
         cyc(1, 1, 1, cap[i], 0);
         $display("gap shift %0d: out=%02h cnt=%0d done=%0d", i, out, cnt, word_done);
         chk_model($sformatf("gap%0d", i));
         if (i == 3) begin
            for (int g = 0; g < 3; g++) begin
               cyc(1, 0, 1, 1, 0);
               chk("gap.cnt_hold", 32'(cnt), 4);
               chk("gap.no_done",  32'(word_done), 0);
            end
         end
      end
      chk("gap.final_out",  32'(out), 32'h B2);
      chk("gap.final_done", 32'(word_done), 1);

      // Mid-word abort by CLR, then by reset.
      for (int i = 0; i < 5; i++) cyc(1, 1, 1, 1, 0);
      cyc(1, 1, 7, 0, 0);
      $display("abort clr: out=%02h cnt=%0d done=%0d", out, cnt, word_done);
      chk("abort.clr_out",  32'(out), 0);
      chk("abort.clr_cnt",  32'(cnt), 0);
      chk("abort.clr_done", 32'(word_done), 0);
      for (int i = 0; i < 5; i++) cyc(1, 1, 1, 1, 0);
      cyc(0, 1, 1, 1, 0);
      $display("abort rst: out=%02h cnt=%0d done=%0d", out, cnt, word_done);
      chk("abort.rst_out", 32'(out), 32'h A5);
      chk("abort.rst_cnt", 32'(cnt), 0);

      // Back-to-back words: one pulse per 8 shifts.
      pulses = 0;
      for (int i = 0; i < 16; i++) begin
         cyc(1, 1, 1 + (i % 5), i[0], 0);
         if (word_done) pulses++;
      end
      $display("back-to-back: pulses=%0d", pulses);
      chk("b2b.pulses", 32'(pulses), 2);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         bit r = ($urandom_range(0, 99) >= 3);
         bit e = ($urandom_range(0, 99) < 80);
         int md = $urandom_range(0, 7);
         if (md >= 6 && $urandom_range(0, 2) != 0) md = $urandom_range(1, 5);
         cyc(r, e, md, 1'($urandom), int'($urandom_range(0, 255)));
         $display("rand %0d r=%0d en=%0d mode=%0d -> out=%02h sout=%0d cnt=%0d done=%0d",
                  i, r, e, md, out, sout, cnt, word_done);
         chk_model($sformatf("rand%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
